rob_commit_unit: RTL and testbench

- Reorder buffer that supplies rename tags to the register alias table and later returns them.
- Allocates one in-order entry per dispatched instruction and hands its tag to rename.
- Collects out-of-order results from two writeback buses.
- Retires up to two completed entries per cycle in program order, driving the arch-register free signals the alias table consumes.

---
 rtl/rob_commit_unit_pkg.sv | 33 +++
 rtl/rob_ptr_ctrl.sv | 60 ++++++
 rtl/rob_commit_unit.sv | 177 +++++++++++++++++
 tb/tb_rob_commit_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_unit_pkg.sv
// ============================================================================
// Module      : rob_commit_unit_pkg
// Description : Shared constants and record types for the reorder buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rob_commit_unit_pkg;

    localparam int ROB_DEPTH = 32;
    localparam int TAG_W     = 5;
    localparam int REG_W     = 5;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_dest;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

    typedef struct packed {
        logic              valid;
        logic              has_dest;
        logic [REG_W-1:0]  dest;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } commit_t;

endpackage

`default_nettype wire

// File: rtl/rob_ptr_ctrl.sv
// ============================================================================
// Module      : rob_ptr_ctrl
// Description : Head/tail/occupancy bookkeeping for the reorder buffer ring.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_ptr_ctrl
    import rob_commit_unit_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int PTR_W = TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc_req,
    input  logic             commit0_valid,
    input  logic             commit1_valid,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [PTR_W:0]   count,
    output logic             alloc_ready,
    output logic             alloc_fire
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       w_retire_cnt;

    // Fullness is judged on current occupancy only, so a same-cycle retire
    // never opens a slot for a same-cycle allocation.
    assign alloc_ready = (r_count != CNT_W'(DEPTH));
    assign alloc_fire  = alloc_req && alloc_ready && !flush;

    // commit1 can only be set alongside commit0
    assign w_retire_cnt = commit1_valid ? 2'd2 : (commit0_valid ? 2'd1 : 2'd0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_retire_cnt);
            r_tail  <= r_tail + PTR_W'(alloc_fire);
            r_count <= r_count + CNT_W'(alloc_fire) - CNT_W'(w_retire_cnt);
        end
    end

    assign head  = r_head;
    assign tail  = r_tail;
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/rob_commit_unit.sv
// ============================================================================
// Module      : rob_commit_unit
// Description : Reorder buffer with dual writeback, dual in-order retire and
//               two operand lookup ports. ROB_WB_BYPASS_EN makes same-cycle
//               writebacks visible on the lookup ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_commit_unit
    import rob_commit_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    input  logic              alloc_has_dest,
    input  logic [REG_W-1:0]  alloc_dest,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb0_valid,
    input  logic [TAG_W-1:0]  wb0_tag,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb1_valid,
    input  logic [TAG_W-1:0]  wb1_tag,
    input  logic [DATA_W-1:0] wb1_data,
    input  logic [TAG_W-1:0]  rd_tag_a,
    input  logic [TAG_W-1:0]  rd_tag_b,
    output logic              rd_ready_a,
    output logic              rd_ready_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              flush,
    output logic              commit0_valid,
    output logic              commit0_has_dest,
    output logic [REG_W-1:0]  commit0_dest,
    output logic [TAG_W-1:0]  commit0_tag,
    output logic [DATA_W-1:0] commit0_data,
    output logic              commit1_valid,
    output logic              commit1_has_dest,
    output logic [REG_W-1:0]  commit1_dest,
    output logic [TAG_W-1:0]  commit1_tag,
    output logic [DATA_W-1:0] commit1_data,
    output logic [TAG_W:0]    count
);

    rob_entry_t        r_entries [ROB_DEPTH];
    logic [TAG_W-1:0]  w_head;
    logic [TAG_W-1:0]  w_head1;
    logic [TAG_W-1:0]  w_tail;
    logic              w_alloc_fire;
    rob_entry_t        w_e0;
    rob_entry_t        w_e1;
    commit_t           w_c0;
    commit_t           w_c1;
    logic [TAG_W-1:0]  w_rd_tag   [2];
    logic              w_rd_ready [2];
    logic [DATA_W-1:0] w_rd_data  [2];

    rob_ptr_ctrl #(
        .DEPTH (ROB_DEPTH),
        .PTR_W (TAG_W)
    ) u_ptr_ctrl (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .alloc_req     (alloc_req),
        .commit0_valid (w_c0.valid),
        .commit1_valid (w_c1.valid),
        .head          (w_head),
        .tail          (w_tail),
        .count         (count),
        .alloc_ready   (alloc_ready),
        .alloc_fire    (w_alloc_fire)
    );

    assign alloc_tag = w_tail;

    always_comb begin
        w_head1 = w_head + TAG_W'(1);
        w_e0    = r_entries[w_head];
        w_e1    = r_entries[w_head1];
        w_c0    = '0;
        w_c1    = '0;
        if (!flush) begin
            w_c0.valid    = w_e0.valid && w_e0.done;
            w_c0.has_dest = w_e0.has_dest;
            w_c0.dest     = w_e0.dest;
            w_c0.tag      = w_head;
            w_c0.data     = w_e0.data;
            // head+1 may only retire behind a retiring head
            w_c1.valid    = w_c0.valid && w_e1.valid && w_e1.done;
            w_c1.has_dest = w_e1.has_dest;
            w_c1.dest     = w_e1.dest;
            w_c1.tag      = w_head1;
            w_c1.data     = w_e1.data;
        end
    end

    assign commit0_valid    = w_c0.valid;
    assign commit0_has_dest = w_c0.has_dest;
    assign commit0_dest     = w_c0.dest;
    assign commit0_tag      = w_c0.tag;
    assign commit0_data     = w_c0.data;
    assign commit1_valid    = w_c1.valid;
    assign commit1_has_dest = w_c1.has_dest;
    assign commit1_dest     = w_c1.dest;
    assign commit1_tag      = w_c1.tag;
    assign commit1_data     = w_c1.data;

    // Later assignments win: wb1 over wb0, retire clears, then allocation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_entries[i].valid    <= 1'b0;
                r_entries[i].done     <= 1'b0;
                r_entries[i].has_dest <= 1'b0;
                r_entries[i].dest     <= '0;
            end
        end else begin
            if (wb0_valid && r_entries[wb0_tag].valid) begin
                r_entries[wb0_tag].done <= 1'b1;
                r_entries[wb0_tag].data <= wb0_data;
            end
            if (wb1_valid && r_entries[wb1_tag].valid) begin
                r_entries[wb1_tag].done <= 1'b1;
                r_entries[wb1_tag].data <= wb1_data;
            end
            if (w_c0.valid) begin
                r_entries[w_head].valid <= 1'b0;
                r_entries[w_head].done  <= 1'b0;
            end
            if (w_c1.valid) begin
                r_entries[w_head1].valid <= 1'b0;
                r_entries[w_head1].done  <= 1'b0;
            end
            if (w_alloc_fire) begin
                r_entries[w_tail].valid    <= 1'b1;
                r_entries[w_tail].done     <= 1'b0;
                r_entries[w_tail].has_dest <= alloc_has_dest;
                r_entries[w_tail].dest     <= alloc_dest;
            end
        end
    end

    assign w_rd_tag[0] = rd_tag_a;
    assign w_rd_tag[1] = rd_tag_b;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_ready[p] = r_entries[w_rd_tag[p]].valid && r_entries[w_rd_tag[p]].done;
            w_rd_data[p]  = r_entries[w_rd_tag[p]].data;
`ifdef ROB_WB_BYPASS_EN
            if (r_entries[w_rd_tag[p]].valid) begin
                if (wb1_valid && (wb1_tag == w_rd_tag[p])) begin
                    w_rd_ready[p] = 1'b1;
                    w_rd_data[p]  = wb1_data;
                end else if (wb0_valid && (wb0_tag == w_rd_tag[p])) begin
                    w_rd_ready[p] = 1'b1;
                    w_rd_data[p]  = wb0_data;
                end
            end
`endif
        end
    end

    assign rd_ready_a = w_rd_ready[0];
    assign rd_data_a  = w_rd_data[0];
    assign rd_ready_b = w_rd_ready[1];
    assign rd_data_b  = w_rd_data[1];

endmodule

`default_nettype wire

// File: tb/tb_rob_commit_unit.sv
// ============================================================================
// Module      : tb_rob_commit_unit
// Description : Directed self-checking bench for rob_commit_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rob_commit_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_req = 1'b0;
    logic        alloc_has_dest = 1'b0;
    logic [4:0]  alloc_dest = '0;
    logic        alloc_ready;
    logic [4:0]  alloc_tag;
    logic        wb0_valid = 1'b0;
    logic [4:0]  wb0_tag = '0;
    logic [31:0] wb0_data = '0;
    logic        wb1_valid = 1'b0;
    logic [4:0]  wb1_tag = '0;
    logic [31:0] wb1_data = '0;
    logic [4:0]  rd_tag_a = '0;
    logic [4:0]  rd_tag_b = '0;
    logic        rd_ready_a, rd_ready_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        flush = 1'b0;
    logic        commit0_valid, commit0_has_dest;
    logic [4:0]  commit0_dest, commit0_tag;
    logic [31:0] commit0_data;
    logic        commit1_valid, commit1_has_dest;
    logic [4:0]  commit1_dest, commit1_tag;
    logic [31:0] commit1_data;
    logic [5:0]  count;

    int checks = 0;
    int errors = 0;

    rob_commit_unit dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_req        (alloc_req),
        .alloc_has_dest   (alloc_has_dest),
        .alloc_dest       (alloc_dest),
        .alloc_ready      (alloc_ready),
        .alloc_tag        (alloc_tag),
        .wb0_valid        (wb0_valid),
        .wb0_tag          (wb0_tag),
        .wb0_data         (wb0_data),
        .wb1_valid        (wb1_valid),
        .wb1_tag          (wb1_tag),
        .wb1_data         (wb1_data),
        .rd_tag_a         (rd_tag_a),
        .rd_tag_b         (rd_tag_b),
        .rd_ready_a       (rd_ready_a),
        .rd_ready_b       (rd_ready_b),
        .rd_data_a        (rd_data_a),
        .rd_data_b        (rd_data_b),
        .flush            (flush),
        .commit0_valid    (commit0_valid),
        .commit0_has_dest (commit0_has_dest),
        .commit0_dest     (commit0_dest),
        .commit0_tag      (commit0_tag),
        .commit0_data     (commit0_data),
        .commit1_valid    (commit1_valid),
        .commit1_has_dest (commit1_has_dest),
        .commit1_dest     (commit1_dest),
        .commit1_tag      (commit1_tag),
        .commit1_data     (commit1_data),
        .count            (count)
    );

    always #5 clk = ~clk;

    // One clock edge, then all strobes drop; outputs settle before any check.
    task automatic cycle();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        alloc_req = 1'b0;
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        flush     = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
    endtask

    task automatic alloc(input logic hd, input logic [4:0] dest);
        alloc_req      = 1'b1;
        alloc_has_dest = hd;
        alloc_dest     = dest;
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %b expected 1", alloc_ready); end
        checks++; if (alloc_tag !== 5'd0) begin errors++; $display("FAIL reset_alloc_tag: got %0d expected 0", alloc_tag); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if ({commit0_valid, commit1_valid, rd_ready_a} !== 3'b000) begin errors++; $display("FAIL reset_valids: got %b expected 000", {commit0_valid, commit1_valid, rd_ready_a}); end
    endtask

    task automatic test_alloc();
        for (int i = 0; i < 3; i++) begin
            logic [4:0] exp_tag;
            exp_tag        = 5'(i);
            alloc_req      = 1'b1;
            alloc_has_dest = 1'b1;
            alloc_dest     = 5'(i + 1);
            #1;
            checks++; if (alloc_tag !== exp_tag) begin errors++; $display("FAIL alloc_tag_%0d: got %0d expected %0d", i, alloc_tag, exp_tag); end
            cycle();
        end
        checks++; if (count !== 6'd3) begin errors++; $display("FAIL alloc_count: got %0d expected 3", count); end
        checks++; if (commit0_valid !== 1'b0) begin errors++; $display("FAIL alloc_no_commit: got %b expected 0", commit0_valid); end
    endtask

    task automatic test_in_order();
        wb0_valid = 1'b1; wb0_tag = 5'd2; wb0_data = 32'h22;
        cycle();
        rd_tag_a = 5'd2;
        #1;
        checks++; if (commit0_valid !== 1'b0) begin errors++; $display("FAIL order_head_blocks: got %b expected 0", commit0_valid); end
        checks++; if ({rd_ready_a, rd_data_a} !== {1'b1, 32'h22}) begin errors++; $display("FAIL order_rd_tag2: got %b/%h expected 1/00000022", rd_ready_a, rd_data_a); end
        wb0_valid = 1'b1; wb0_tag = 5'd0; wb0_data = 32'h100;
        cycle();
        checks++; if ({commit0_valid, commit0_tag, commit0_dest, commit0_data} !== {1'b1, 5'd0, 5'd1, 32'h100})
            begin errors++; $display("FAIL order_commit_tag0: got v%b t%0d d%0d %h expected v1 t0 d1 00000100", commit0_valid, commit0_tag, commit0_dest, commit0_data); end
        checks++; if (commit1_valid !== 1'b0) begin errors++; $display("FAIL order_commit1_blocked: got %b expected 0", commit1_valid); end
        wb1_valid = 1'b1; wb1_tag = 5'd1; wb1_data = 32'h11;
        cycle();
        checks++; if ({commit0_valid, commit0_tag, commit0_dest, commit0_data} !== {1'b1, 5'd1, 5'd2, 32'h11})
            begin errors++; $display("FAIL order_pair_c0: got v%b t%0d d%0d %h expected v1 t1 d2 00000011", commit0_valid, commit0_tag, commit0_dest, commit0_data); end
        checks++; if ({commit1_valid, commit1_tag, commit1_dest, commit1_data} !== {1'b1, 5'd2, 5'd3, 32'h22})
            begin errors++; $display("FAIL order_pair_c1: got v%b t%0d d%0d %h expected v1 t2 d3 00000022", commit1_valid, commit1_tag, commit1_dest, commit1_data); end
        checks++; if (count !== 6'd2) begin errors++; $display("FAIL order_count_mid: got %0d expected 2", count); end
        cycle();
        checks++; if ({count, commit0_valid} !== {6'd0, 1'b0}) begin errors++; $display("FAIL order_drained: got count %0d v%b expected 0 v0", count, commit0_valid); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            alloc(i[0], 5'(i));
        end
        checks++; if ({alloc_ready, count} !== {1'b0, 6'd32}) begin errors++; $display("FAIL full_state: got ready %b count %0d expected 0 32", alloc_ready, count); end
        alloc(1'b1, 5'd9);
        checks++; if ({count, alloc_tag} !== {6'd32, 5'd0}) begin errors++; $display("FAIL full_ignored: got count %0d tag %0d expected 32 0", count, alloc_tag); end
        wb0_valid = 1'b1; wb0_tag = 5'd0; wb0_data = 32'h5;
        cycle();
        alloc_req = 1'b1; alloc_has_dest = 1'b1; alloc_dest = 5'd7;
        #1;
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_commit_no_ready: got %b expected 0", alloc_ready); end
        checks++; if ({commit0_valid, commit0_has_dest, commit0_tag, commit0_data} !== {1'b1, 1'b0, 5'd0, 32'h5})
            begin errors++; $display("FAIL full_commit0: got v%b hd%b t%0d %h expected v1 hd0 t0 00000005", commit0_valid, commit0_has_dest, commit0_tag, commit0_data); end
        cycle();
        checks++; if ({count, alloc_ready} !== {6'd31, 1'b1}) begin errors++; $display("FAIL full_after_commit: got count %0d ready %b expected 31 1", count, alloc_ready); end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            alloc(1'b0, 5'(i));
        end
        for (int i = 0; i < 15; i++) begin
            wb0_valid = 1'b1; wb0_tag = 5'(2 * i);     wb0_data = 32'(i);
            wb1_valid = 1'b1; wb1_tag = 5'(2 * i + 1); wb1_data = 32'(i);
            cycle();
        end
        n = 0;
        while (count != 6'd0 && n < 40) begin
            cycle();
            n++;
        end
        checks++; if ({count, alloc_tag} !== {6'd0, 5'd30}) begin errors++; $display("FAIL wrap_setup: got count %0d tag %0d expected 0 30", count, alloc_tag); end
        for (int i = 0; i < 4; i++) begin
            logic [4:0] exp_tag;
            exp_tag        = 5'(30 + i);
            alloc_req      = 1'b1;
            alloc_has_dest = 1'b1;
            alloc_dest     = 5'(10 + i);
            #1;
            checks++; if (alloc_tag !== exp_tag) begin errors++; $display("FAIL wrap_alloc_tag_%0d: got %0d expected %0d", i, alloc_tag, exp_tag); end
            cycle();
        end
        wb0_valid = 1'b1; wb0_tag = 5'd31; wb0_data = 32'h31;
        wb1_valid = 1'b1; wb1_tag = 5'd30; wb1_data = 32'h30;
        cycle();
        checks++; if ({commit0_valid, commit0_tag, commit0_dest, commit0_data, commit1_valid, commit1_tag, commit1_dest, commit1_data}
                      !== {1'b1, 5'd30, 5'd10, 32'h30, 1'b1, 5'd31, 5'd11, 32'h31})
            begin errors++; $display("FAIL wrap_pair_30_31: got c0 v%b t%0d c1 v%b t%0d expected c0 v1 t30 c1 v1 t31", commit0_valid, commit0_tag, commit1_valid, commit1_tag); end
        wb0_valid = 1'b1; wb0_tag = 5'd0; wb0_data = 32'hA0;
        wb1_valid = 1'b1; wb1_tag = 5'd1; wb1_data = 32'hA1;
        cycle();
        checks++; if ({commit0_valid, commit0_tag, commit0_dest, commit0_data, commit1_valid, commit1_tag, commit1_dest, commit1_data}
                      !== {1'b1, 5'd0, 5'd12, 32'hA0, 1'b1, 5'd1, 5'd13, 32'hA1})
            begin errors++; $display("FAIL wrap_pair_0_1: got c0 v%b t%0d c1 v%b t%0d expected c0 v1 t0 c1 v1 t1", commit0_valid, commit0_tag, commit1_valid, commit1_tag); end
        cycle();
        checks++; if ({count, commit0_valid} !== {6'd0, 1'b0}) begin errors++; $display("FAIL wrap_drained: got count %0d v%b expected 0 v0", count, commit0_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc(1'b1, 5'(20 + i));
        end
        wb0_valid = 1'b1; wb0_tag = 5'd0; wb0_data = 32'h77;
        cycle();
        flush     = 1'b1;
        alloc_req = 1'b1; alloc_has_dest = 1'b1; alloc_dest = 5'd9;
        wb1_valid = 1'b1; wb1_tag = 5'd2; wb1_data = 32'h99;
        #1;
        checks++; if ({commit0_valid, commit0_dest, commit1_valid} !== {1'b0, 5'd0, 1'b0})
            begin errors++; $display("FAIL flush_commit_forced: got v%b d%0d v1%b expected v0 d0 v1 0", commit0_valid, commit0_dest, commit1_valid); end
        cycle();
        rd_tag_a = 5'd0;
        rd_tag_b = 5'd2;
        #1;
        checks++; if ({count, alloc_tag, commit0_valid} !== {6'd0, 5'd0, 1'b0})
            begin errors++; $display("FAIL flush_state: got count %0d tag %0d v%b expected 0 0 v0", count, alloc_tag, commit0_valid); end
        checks++; if ({rd_ready_a, rd_ready_b} !== 2'b00) begin errors++; $display("FAIL flush_rd_ready: got %b expected 00", {rd_ready_a, rd_ready_b}); end
        checks++; if (rd_data_a !== 32'h77) begin errors++; $display("FAIL flush_data_kept: got %h expected 00000077", rd_data_a); end
        checks++; if (rd_data_b !== 32'h0) begin errors++; $display("FAIL flush_wb_discarded: got %h expected 00000000", rd_data_b); end
    endtask

    task automatic test_collision();
        for (int i = 0; i < 5; i++) begin
            alloc(1'b1, 5'(i));
        end
        wb0_valid = 1'b1; wb0_tag = 5'd4; wb0_data = 32'hAA;
        wb1_valid = 1'b1; wb1_tag = 5'd4; wb1_data = 32'hBB;
        rd_tag_a  = 5'd4;
        #1;
`ifdef ROB_WB_BYPASS_EN
        checks++; if ({rd_ready_a, rd_data_a} !== {1'b1, 32'hBB}) begin errors++; $display("FAIL coll_bypass: got %b/%h expected 1/000000bb", rd_ready_a, rd_data_a); end
`else
        checks++; if (rd_ready_a !== 1'b0) begin errors++; $display("FAIL coll_no_bypass: got %b expected 0", rd_ready_a); end
`endif
        cycle();
        checks++; if ({rd_ready_a, rd_data_a} !== {1'b1, 32'hBB}) begin errors++; $display("FAIL coll_stored: got %b/%h expected 1/000000bb", rd_ready_a, rd_data_a); end
        checks++; if (commit0_valid !== 1'b0) begin errors++; $display("FAIL coll_head_undone: got %b expected 0", commit0_valid); end
        wb0_valid = 1'b1; wb0_tag = 5'd10; wb0_data = 32'h55;
        cycle();
        rd_tag_b = 5'd10;
        #1;
        checks++; if ({rd_ready_b, rd_data_b} !== {1'b0, 32'h0}) begin errors++; $display("FAIL wb_invalid_ignored: got %b/%h expected 0/00000000", rd_ready_b, rd_data_b); end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_in_order();
        test_full();
        test_wrap();
        test_flush();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
